// File: rtl/key_req_cond_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_req_cond_pkg                                                           |
// | Shared key-channel state encodings and debounce timing defaults.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package key_req_cond_pkg;

    typedef enum logic [1:0] {
        KS_REL   = 2'b00,
        KS_PRE_Q = 2'b01,
        KS_HELD  = 2'b10,
        KS_REL_Q = 2'b11
    } ks_state_t;

    // 20 ms of stable level at 50 MHz
    localparam int c_DEB_CNT_DEF = 1000000;
    localparam int c_CNT_W_DEF   = 20;

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce_ch                                                            |
// | One key channel: 2-FF synchroniser, counter debounce, press pulse.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module key_debounce_ch
    import key_req_cond_pkg::*;
#(
    parameter int DEB_CNT    = c_DEB_CNT_DEF,
    parameter int CNT_W      = c_CNT_W_DEF,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic en,
    input  logic key_raw,
    output logic xdkey,
    output logic key_lvl,
    output logic key_busy
);

    localparam logic             c_REL_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEB_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_pressed;
    ks_state_t        r_state;
    ks_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse;
    logic             r_xdkey;
    logic             r_lvl;
    logic             r_busy;

    // Flipping the synchronised level by the released level yields 1 = pressed
    assign w_pressed = r_sync2 ^ c_REL_LVL;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse     = 1'b0;
        case (r_state)
            KS_REL: begin
                if (w_pressed) begin
                    w_state_nxt = KS_PRE_Q;
                    w_cnt_nxt   = '0;
                end
            end
            KS_PRE_Q: begin
                if (!w_pressed) begin
                    w_state_nxt = KS_REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = KS_HELD;
                    w_cnt_nxt   = '0;
                    w_pulse     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            KS_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = KS_REL_Q;
                    w_cnt_nxt   = '0;
                end
            end
            KS_REL_Q: begin
                if (w_pressed) begin
                    w_state_nxt = KS_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = KS_REL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = KS_REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_sync1 <= c_REL_LVL;
            r_sync2 <= c_REL_LVL;
            r_state <= KS_REL;
            r_cnt   <= '0;
            r_xdkey <= 1'b0;
            r_lvl   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_xdkey <= w_pulse;
            r_lvl   <= (w_state_nxt == KS_HELD) || (w_state_nxt == KS_REL_Q);
            r_busy  <= (w_state_nxt == KS_PRE_Q) || (w_state_nxt == KS_REL_Q);
        end
    end

    assign xdkey    = r_xdkey;
    assign key_lvl  = r_lvl;
    assign key_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/key_req_cond.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_req_cond                                                               |
// | Conditions raw push-buttons into one-cycle request pulses (xdkey).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module key_req_cond
    import key_req_cond_pkg::*;
#(
    parameter int NKEY       = 4,
    parameter int DEB_CNT    = c_DEB_CNT_DEF,
    parameter int CNT_W      = c_CNT_W_DEF,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            en,
    input  logic [NKEY-1:0] key_raw,
    output logic [NKEY-1:0] xdkey,
    output logic [NKEY-1:0] key_lvl,
    output logic [NKEY-1:0] key_busy
);

    genvar i;
    generate
        for (i = 0; i < NKEY; i = i + 1) begin : g_ch
            key_debounce_ch #(
                .DEB_CNT    (DEB_CNT),
                .CNT_W      (CNT_W),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_ch (
                .clk      (clk),
                .en       (en),
                .key_raw  (key_raw[i]),
                .xdkey    (xdkey[i]),
                .key_lvl  (key_lvl[i]),
                .key_busy (key_busy[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_req_cond.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_req_cond                                                            |
// | Directed table and sequence bench for key_req_cond (DEB_CNT=8).            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_key_req_cond;

    logic       clk = 1'b0;
    logic       en;
    logic [3:0] key_raw;
    logic [3:0] xdkey;
    logic [3:0] key_lvl;
    logic [3:0] key_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt [4] = '{default: 0};

    key_req_cond #(
        .NKEY       (4),
        .DEB_CNT    (8),
        .CNT_W      (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .en       (en),
        .key_raw  (key_raw),
        .xdkey    (xdkey),
        .key_lvl  (key_lvl),
        .key_busy (key_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (xdkey[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end

    typedef struct {
        logic       en;
        logic [3:0] raw;
        int         hold;
        logic [3:0] x;
        logic [3:0] lvl;
        logic [3:0] busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        en      = 1'b1;
        key_raw = 4'b0000;

        // reset with all keys held, then full press/release of every channel
        vecs[0]  = '{1'b1, 4'b0000,    2, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 4'b0000,   10, 4'h0, 4'h0, 4'hF};
        vecs[2]  = '{1'b0, 4'b0000,    1, 4'hF, 4'hF, 4'h0};
        vecs[3]  = '{1'b0, 4'b0000,    1, 4'h0, 4'hF, 4'h0};
        vecs[4]  = '{1'b0, 4'b1111,   10, 4'h0, 4'hF, 4'hF};
        vecs[5]  = '{1'b0, 4'b1111,    1, 4'h0, 4'h0, 4'h0};
        // key1 clean press, long hold, release
        vecs[6]  = '{1'b0, 4'b1101,   10, 4'h0, 4'h0, 4'h2};
        vecs[7]  = '{1'b0, 4'b1101,    1, 4'h2, 4'h2, 4'h0};
        vecs[8]  = '{1'b0, 4'b1101, 1000, 4'h0, 4'h2, 4'h0};
        vecs[9]  = '{1'b0, 4'b1111,   10, 4'h0, 4'h2, 4'h2};
        vecs[10] = '{1'b0, 4'b1111,    1, 4'h0, 4'h0, 4'h0};
        // key0+key2 together, release key2 first
        vecs[11] = '{1'b0, 4'b1010,   10, 4'h0, 4'h0, 4'h5};
        vecs[12] = '{1'b0, 4'b1010,    1, 4'h5, 4'h5, 4'h0};
        vecs[13] = '{1'b0, 4'b1010,    1, 4'h0, 4'h5, 4'h0};
        vecs[14] = '{1'b0, 4'b1110,   10, 4'h0, 4'h5, 4'h4};
        vecs[15] = '{1'b0, 4'b1110,    1, 4'h0, 4'h1, 4'h0};
        vecs[16] = '{1'b0, 4'b1111,   11, 4'h0, 4'h0, 4'h0};

        for (int v = 0; v < NVEC; v++) begin
            en      = vecs[v].en;
            key_raw = vecs[v].raw;
            repeat (vecs[v].hold) tick();
            chk($sformatf("vec%0d xdkey", v),    32'(xdkey),    32'(vecs[v].x));
            chk($sformatf("vec%0d key_lvl", v),  32'(key_lvl),  32'(vecs[v].lvl));
            chk($sformatf("vec%0d key_busy", v), 32'(key_busy), 32'(vecs[v].busy));
        end
        chk("pulses bit0 after table", pulse_cnt[0], 2);
        chk("pulses bit1 after table", pulse_cnt[1], 2);
        chk("pulses bit2 after table", pulse_cnt[2], 2);
        chk("pulses bit3 after table", pulse_cnt[3], 1);

        // key3 bounce: low 5, high 1, low 20 -> single pulse at t+16
        base    = pulse_cnt[3];
        key_raw = 4'b0111;
        repeat (5) tick();
        chk("bounce busy3 first try", 32'(key_busy[3]), 1);
        key_raw = 4'b1111;
        tick();
        key_raw = 4'b0111;
        repeat (10) tick();
        chk("bounce no early pulse", 32'(xdkey), 0);
        chk("bounce busy3 qualifying", 32'(key_busy[3]), 1);
        tick();
        chk("bounce pulse t+16", 32'(xdkey), 32'h8);
        chk("bounce lvl3 up", 32'(key_lvl[3]), 1);
        repeat (9) tick();
        chk("bounce single pulse", pulse_cnt[3] - base, 1);
        key_raw = 4'b1111;
        repeat (11) tick();
        chk("bounce release lvl", 32'(key_lvl), 0);

        // key1 held, 3-cycle release glitch
        key_raw = 4'b1101;
        repeat (11) tick();
        chk("glitch initial pulse", 32'(xdkey), 32'h2);
        repeat (5) tick();
        base    = pulse_cnt[1];
        key_raw = 4'b1111;
        repeat (3) tick();
        chk("glitch busy1 rel_q", 32'(key_busy), 32'h2);
        key_raw = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("glitch lvl1 c%0d", c), 32'(key_lvl[1]), 1);
        end
        chk("glitch no new pulse", pulse_cnt[1] - base, 0);
        chk("glitch busy settled", 32'(key_busy), 0);
        key_raw = 4'b1111;
        repeat (11) tick();
        chk("glitch release lvl", 32'(key_lvl), 0);

        // reset at cnt=5 of key0 qualification
        key_raw = 4'b1110;
        repeat (8) tick();
        chk("midrst busy0 before", 32'(key_busy), 32'h1);
        en = 1'b1;
        tick();
        chk("midrst xdkey in reset", 32'(xdkey), 0);
        chk("midrst lvl in reset", 32'(key_lvl), 0);
        chk("midrst busy in reset", 32'(key_busy), 0);
        en   = 1'b0;
        base = pulse_cnt[0];
        repeat (10) tick();
        chk("midrst no early pulse", 32'(xdkey), 0);
        chk("midrst busy0 requal", 32'(key_busy), 32'h1);
        tick();
        chk("midrst pulse +10", 32'(xdkey), 32'h1);
        tick();
        chk("midrst single pulse", pulse_cnt[0] - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
